// File: rtl/fnd_scan_ctrl.sv
// Multiplexed seven-segment (FND) scan controller.
// Scans DIGITS digits, one slot of SCAN_DIV cycles each. PWM dimming works
// within each slot. Optional leading-zero blanking. Inputs are latched once
// per frame so that a displayed frame never mixes old and new data.
module fnd_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int BRIGHT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [DIGITS-1:0]     com,
    output logic [6:0]            seg_7,
    output logic                  dp_out,
    output logic                  frame_tick
);

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(DIGITS);
    // Wide enough for (2^BRIGHT_W) * SCAN_DIV without overflow
    localparam int PROD_W = BRIGHT_W + CNT_W + 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] value_sh;
    logic [DIGITS-1:0]   dp_sh;
    logic                blank_lz_sh;
    logic [BRIGHT_W-1:0] bright_sh;

    logic                slot_end;
    logic                frame_end;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   thr;
    logic                lit;
    logic [DIGITS-1:0]   sel_onehot;
    logic [DIGITS-1:0]   blank_vec;
    logic                blanked;
    logic [3:0]          nib;
    logic [6:0]          hex_seg;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // On-time threshold for the current brightness, in prescaler cycles
    assign prod = (PROD_W'(bright_sh) + PROD_W'(1)) * PROD_W'(SCAN_DIV);
    assign thr  = prod >> BRIGHT_W;
    assign lit  = (PROD_W'(cnt) < thr);

    assign sel_onehot = DIGITS'(1) << idx;
    assign nib        = 4'(value_sh >> {idx, 2'b00});

    // Digit g is a leading zero when nibbles DIGITS-1 down to g are all zero
    assign blank_vec[0] = 1'b0;
    for (genvar g = 1; g < DIGITS; g++) begin : g_lz
        assign blank_vec[g] = (value_sh[4*DIGITS-1:4*g] == '0);
    end
    assign blanked = blank_lz_sh && |(blank_vec & sel_onehot);

    // Prescaler and digit index
    always_ff @(posedge clk) begin
        if (reset_p) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow capture at the last cycle of each frame
    always_ff @(posedge clk) begin
        if (reset_p) begin
            value_sh    <= '0;
            dp_sh       <= '0;
            blank_lz_sh <= 1'b0;
            bright_sh   <= '0;
        end else if (frame_end) begin
            value_sh    <= value;
            dp_sh       <= dp;
            blank_lz_sh <= blank_lz;
            bright_sh   <= bright;
        end
    end

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    always_comb begin
        hex_seg = 7'h7F;
        case (nib)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0011000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b0100111;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            4'hF: hex_seg = 7'b0001110;
            default: hex_seg = 7'h7F;
        endcase
    end

    // Registered display outputs and frame pulse; segments go dark together with commons
    always_ff @(posedge clk) begin
        if (reset_p) begin
            com        <= '1;
            seg_7      <= 7'h7F;
            dp_out     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (lit && !blanked) begin
                com    <= ~sel_onehot;
                seg_7  <= hex_seg;
                dp_out <= ~|(dp_sh & sel_onehot);
            end else begin
                com    <= '1;
                seg_7  <= 7'h7F;
                dp_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomized self-checking bench for fnd_scan_ctrl against a time-based
// behavioural model (slot and phase derived from elapsed cycles).
module tb_fnd_scan_ctrl;

    localparam int DIG  = 4;
    localparam int SDIV = 8;
    localparam int BW   = 3;
    localparam int FRAME = DIG * SDIV;

    logic                clk = 1'b0;
    logic                reset_p = 1'b1;
    logic [4*DIG-1:0]    value = '0;
    logic [DIG-1:0]      dp = '0;
    logic                blank_lz = 1'b0;
    logic [BW-1:0]       bright = '0;
    logic [DIG-1:0]      com;
    logic [6:0]          seg_7;
    logic                dp_out;
    logic                frame_tick;

    int checks = 0;
    int failures = 0;

    // Model state
    int             t;
    logic [15:0]    m_value;
    logic [3:0]     m_dp;
    logic           m_blz;
    int             m_bright;
    logic [6:0]     hex_tbl [16];

    logic [3:0]     e_com;
    logic [6:0]     e_seg;
    logic           e_dp;
    logic           e_tick;

    fnd_scan_ctrl #(
        .DIGITS  (DIG),
        .SCAN_DIV(SDIV),
        .BRIGHT_W(BW)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .value     (value),
        .dp        (dp),
        .blank_lz  (blank_lz),
        .bright    (bright),
        .com       (com),
        .seg_7     (seg_7),
        .dp_out    (dp_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h time=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: predict what the edge produces, advance the model, compare
    task automatic step();
        int  slot, pos, thr;
        logic [3:0] nibv;
        bit  lit, blank;
        @(posedge clk);
        if (reset_p) begin
            e_com = '1; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
            t = 0; m_value = '0; m_dp = '0; m_blz = 1'b0; m_bright = 0;
        end else begin
            slot  = (t / SDIV) % DIG;
            pos   = t % SDIV;
            thr   = ((m_bright + 1) * SDIV) >> BW;
            lit   = (pos < thr);
            blank = m_blz && (slot > 0) && ((m_value >> (4 * slot)) == 16'h0);
            nibv  = 4'((m_value >> (4 * slot)) & 16'hF);
            if (lit && !blank) begin
                e_com = 4'hF ^ (4'h1 << slot);
                e_seg = hex_tbl[nibv];
                e_dp  = ~m_dp[slot];
            end else begin
                e_com = '1; e_seg = 7'h7F; e_dp = 1'b1;
            end
            e_tick = ((t % FRAME) == FRAME - 1);
            if (e_tick) begin
                m_value = value; m_dp = dp; m_blz = blank_lz; m_bright = int'(bright);
            end
            t++;
        end
        #1;
        check("com", 32'(com), 32'(e_com));
        check("seg_7", 32'(seg_7), 32'(e_seg));
        check("dp_out", 32'(dp_out), 32'(e_dp));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        hex_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};
        t = 0; m_value = '0; m_dp = '0; m_blz = 1'b0; m_bright = 0;

        // Reset, then first frame shows shadow zeros; display pattern held
        run(3);
        reset_p = 1'b0;
        value = 16'h12AF; bright = 3'd7; dp = 4'b0100; blank_lz = 1'b0;
        run(3 * FRAME);

        // Reduced brightness
        bright = 3'd2;
        run(2 * FRAME + 5);

        // Leading-zero blanking, then all-zero value
        value = 16'h0050; blank_lz = 1'b1; bright = 3'd7;
        run(2 * FRAME);
        value = 16'h0000;
        run(2 * FRAME);

        // No tearing: change data while digit 1 is being scanned
        value = 16'h1111; blank_lz = 1'b0;
        run(2 * FRAME);
        while (((t / SDIV) % DIG) != 1) step();
        run(3);
        value = 16'h2222;
        run(3 * FRAME);

        // Reset in the middle of a frame
        run(13);
        reset_p = 1'b1;
        run(1);
        reset_p = 1'b0;
        run(2 * FRAME);

        // Randomized inputs with occasional resets
        for (int i = 0; i < 1600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                value    = 16'($urandom);
                if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
                if ($urandom_range(0, 4) == 0) value = value & 16'h000F;
                dp       = 4'($urandom);
                blank_lz = 1'($urandom);
                bright   = 3'($urandom);
            end
            reset_p = ($urandom_range(0, 199) == 0);
            step();
        end
        reset_p = 1'b0;
        run(FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
